// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response and decode-side FIFO head.
// The master modport is the fetch unit's view; slave is memory plus decode.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

interface ifetch_if;
  logic                 imem_req_o;
  logic [`PC_SIZE-1:0]  imem_addr_o;
  logic                 imem_ack_i;
  logic [31:0]          imem_data_i;
  logic                 instr_valid_o;
  logic [31:0]          instr_o;
  logic [`PC_SIZE-1:0]  instr_pc_o;
  logic                 instr_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  imem_ack_i, imem_data_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output imem_ack_i, imem_data_i, instr_ready_i
  );
endinterface

// File: rtl/ifetch.sv
// Instruction-fetch front end: single-outstanding memory requests, PC stall control,
// and a small circular buffer of {pc, instruction} toward decode.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module ifetch #(
  parameter int DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic [`PC_SIZE-1:0] pc_addr_i,
  output logic                pc_stall_o,
  input  logic                flush_i,
  ifetch_if.master            bus
);
  localparam int AW = `PC_SIZE;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [PW-1:0] ONE_P      = PW'(1);
  localparam logic [AW-1:0] INSN_BYTES = AW'(4);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_req, w_req_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;

  logic [31:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_pc_mem   [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic          w_valid, w_pop, w_push;
  logic [CW-1:0] w_count_after;

  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid & bus.instr_ready_i;
  assign w_push        = (r_state == S_REQ) & bus.imem_ack_i & ~flush_i & ~reset_i;
  // Occupancy once this cycle's pop and push have both landed.
  assign w_count_after = r_count - {{(CW-1){1'b0}}, w_pop} + ONE_C;

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (enable_i & ~flush_i & (r_count < FULL)) begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = pc_addr_i;
        end
      end
      S_REQ: begin
        if (bus.imem_ack_i) begin
          // Back-to-back issue follows the PC, which advances at this same edge.
          if (~flush_i & enable_i & (w_count_after < FULL)) begin
            w_addr_nxt = pc_addr_i + INSN_BYTES;
          end else begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
          end
        end else if (flush_i) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.imem_ack_i) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ONE_P;
      if (w_pop)  r_rptr <= r_rptr + ONE_P;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is owned entirely by r_count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data_mem[r_wptr] <= bus.imem_data_i;
      r_pc_mem[r_wptr]   <= r_addr;
    end
  end

  assign bus.imem_req_o    = r_req;
  assign bus.imem_addr_o   = r_addr;
  assign bus.instr_valid_o = w_valid;
  assign bus.instr_o       = r_data_mem[r_rptr];
  assign bus.instr_pc_o    = r_pc_mem[r_rptr];
  assign pc_stall_o        = flush_i ? 1'b0 : ~w_push;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus randomized traffic against a
// program-order model (PC register, latency memory, expected instruction queue).
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module tb_ifetch;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                en = 1'b1;
  logic                fl = 1'b0;
  logic [`PC_SIZE-1:0] pc = '0;
  logic                stall;

  ifetch_if bus();

  ifetch #(.DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .enable_i  (en),
    .pc_addr_i (pc),
    .pc_stall_o(stall),
    .flush_i   (fl),
    .bus       (bus)
  );

  typedef struct packed {
    logic [`PC_SIZE-1:0] pc;
    logic [31:0]         data;
  } ent_t;

  ent_t                m_q[$];
  logic [`PC_SIZE-1:0] m_pc = '0;
  logic [`PC_SIZE-1:0] pc_start = '0;
  logic [`PC_SIZE-1:0] tgt = '0;
  logic [`PC_SIZE-1:0] prev_addr = '0;
  bit  m_ok = 0, m_drop = 0, exp_req = 0, prev_wait = 0, force_ack = 0;
  int  wait_cnt = 0, cur_lat = 0, lat_fixed = 0;
  int  n_push = 0, tot_push = 0;
  int  n_tests = 0, n_fail = 0;

  function automatic logic [31:0] fdata(logic [`PC_SIZE-1:0] a);
    return 32'(a) ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, check outputs, advance the model.
  task automatic tick();
    logic                req, ack, stl;
    logic [`PC_SIZE-1:0] addr;
    bit                  push, pop, nreq, ndrop;
    int                  sz;
    pc = m_pc;
    bus.imem_ack_i  = force_ack || ((bus.imem_req_o === 1'b1) && (wait_cnt >= cur_lat));
    bus.imem_data_i = fdata(bus.imem_addr_o);
    #1;
    req  = bus.imem_req_o;
    ack  = bus.imem_ack_i;
    addr = bus.imem_addr_o;
    stl  = stall;
    sz   = m_q.size();
    push = m_ok && !rst && req && ack && !m_drop && !fl;
    pop  = (sz != 0) && bus.instr_ready_i;
    if (m_ok && !rst) begin
      chk("imem_req", 32'(req), 32'(exp_req));
      if (prev_wait) chk("addr_hold", 32'(addr), 32'(prev_addr));
      if (req && !m_drop) chk("addr_vs_pc", 32'(addr), 32'(m_pc));
      chk("instr_valid", 32'(bus.instr_valid_o), 32'(sz != 0));
      if (sz != 0) begin
        chk("instr_pc", 32'(bus.instr_pc_o), 32'(m_q[0].pc));
        chk("instr", bus.instr_o, m_q[0].data);
      end
      chk("pc_stall", 32'(stl), 32'(!fl && !push));
    end
    if (!req)               nreq = en && !fl && (sz < DEPTH);
    else if (!ack)          nreq = 1'b1;
    else if (m_drop || fl)  nreq = 1'b0;
    else                    nreq = en && ((sz - int'(pop) + 1) < DEPTH);
    ndrop = req && !ack && (fl || m_drop);
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_drop = 0; exp_req = 0; m_pc = pc_start; m_ok = 1;
      prev_wait = 0; wait_cnt = 0; n_push = 0;
    end else begin
      if (fl) m_q.delete();
      else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back('{pc: m_pc, data: fdata(m_pc)});
          n_push++; tot_push++;
        end
      end
      if (fl)        m_pc = tgt;
      else if (!stl) m_pc = m_pc + `PC_SIZE'(4);
      m_drop    = ndrop;
      exp_req   = nreq;
      prev_wait = req && !ack;
      prev_addr = addr;
      if (req && ack) begin
        wait_cnt = 0;
        cur_lat  = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
      end else if (req) wait_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(logic [`PC_SIZE-1:0] start);
    pc_start = start;
    m_pc = start;
    cur_lat = (lat_fixed < 0) ? 0 : lat_fixed;
    rst = 1'b1; force_ack = 1'b1; fl = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_req", 32'(bus.imem_req_o), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    rst = 1'b0; force_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.instr_ready_i = 1'b1;
    bus.imem_ack_i    = 1'b0;
    bus.imem_data_i   = '0;
    @(negedge clk);

    // Zero-wait streaming from 0x0
    lat_fixed = 0;
    do_reset('0);
    repeat (9) tick();
    chk("stream_pushes", 32'(n_push), 32'd8);
    chk("stream_pc", 32'(m_pc), 32'h20);

    // Three wait states per request
    lat_fixed = 3;
    do_reset('0);
    repeat (20) tick();
    chk("wait_pushes", 32'(n_push), 32'd4);
    chk("wait_pc", 32'(m_pc), 32'h10);

    // Backpressure fills the buffer then idles
    lat_fixed = 0;
    bus.instr_ready_i = 1'b0;
    do_reset('0);
    repeat (6) tick();
    chk("bp_pushes", 32'(n_push), 32'd2);
    chk("bp_req_idle", 32'(bus.imem_req_o), 32'd0);
    chk("bp_stall", 32'(stall), 32'd1);
    chk("bp_head_pc", 32'(bus.instr_pc_o), 32'h0);
    chk("bp_pc", 32'(m_pc), 32'h8);
    bus.instr_ready_i = 1'b1;
    tick();
    tick();
    chk("bp_resume_req", 32'(bus.imem_req_o), 32'd1);
    chk("bp_resume_addr", 32'(bus.imem_addr_o), 32'h8);

    // Flush while a request is outstanding
    lat_fixed = 2;
    do_reset(`PC_SIZE'h10);
    tick();
    chk("fl_req_out", 32'(bus.imem_req_o), 32'd1);
    fl = 1'b1; tgt = `PC_SIZE'h100;
    tick();
    fl = 1'b0;
    repeat (2) tick();
    chk("fl_drop_req", 32'(bus.imem_req_o), 32'd0);
    chk("fl_drop_valid", 32'(bus.instr_valid_o), 32'd0);
    tick();
    chk("fl_new_req", 32'(bus.imem_req_o), 32'd1);
    chk("fl_new_addr", 32'(bus.imem_addr_o), 32'h100);

    // Flush coincident with ack and pop on a non-empty buffer
    lat_fixed = 0;
    bus.instr_ready_i = 1'b0;
    do_reset(`PC_SIZE'h40);
    repeat (5) tick();
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    lat_fixed = 2; cur_lat = 2;
    tick();
    chk("fa_issue_addr", 32'(bus.imem_addr_o), 32'h48);
    repeat (2) tick();
    bus.instr_ready_i = 1'b1; fl = 1'b1; tgt = `PC_SIZE'h300;
    tick();
    fl = 1'b0; bus.instr_ready_i = 1'b0;
    chk("fa_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("fa_req", 32'(bus.imem_req_o), 32'd0);
    tick();
    chk("fa_next_addr", 32'(bus.imem_addr_o), 32'h300);

    // Reset in the middle of an outstanding request
    lat_fixed = 6;
    bus.instr_ready_i = 1'b1;
    do_reset(`PC_SIZE'h80);
    repeat (3) tick();
    chk("mr_req_before", 32'(bus.imem_req_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_req_after", 32'(bus.imem_req_o), 32'd0);
    chk("mr_valid_after", 32'(bus.instr_valid_o), 32'd0);

    // Randomized traffic
    lat_fixed = -1;
    tot_push = 0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      bus.instr_ready_i = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? `PC_SIZE'hFFFF_FFF8
                                         : (`PC_SIZE'($urandom) & ~`PC_SIZE'h3);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        force_ack = $urandom_range(0, 1) != 0;
        pc_start = `PC_SIZE'($urandom) & ~`PC_SIZE'h3;
      end
      tick();
      rst = 1'b0;
      force_ack = 1'b0;
    end
    fl = 1'b0;
    chk("rand_progress", 32'(tot_push > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
